// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue-side initiator for the combinational ALU. Accepted instructions are
// held in a small in-order buffer; the oldest one is driven to the ALU, and
// its result is captured into a single writeback slot tagged with the
// instruction's trans_id. The slot decouples ALU timing from writeback
// back-pressure.
//
// Build option:
//   ALU_ISSUE_SKID_EN  defined   -> 2-entry buffer, one instruction per cycle
//                      undefined -> 1-entry holding register, one per 2 cycles
//
// Ports:
//   clk_i             clock, rising edge
//   rst_ni            synchronous active-low reset
//   flush_i           drop buffered and writeback-pending instructions
//   issue_valid_i     fu_data_i carries a valid instruction
//   issue_ready_o     buffer can accept an instruction (function of count only)
//   fu_data_i         incoming instruction
//   alu_fu_data_o     buffer head presented to the ALU (zero when empty)
//   alu_result_i      ALU result for alu_fu_data_o, same cycle
//   alu_branch_res_i  ALU branch outcome for alu_fu_data_o, same cycle
//   wb_valid_o        writeback slot holds a result
//   wb_ready_i        consumer takes the slot this cycle
//   wb_result_o       registered result
//   wb_trans_id_o     trans_id of the registered result
//   wb_branch_res_o   registered branch outcome
// ---------------------------------------------------------------------------

package alu_issue_ctrl_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned TRANS_ID_W = 3;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_OR   = 4'd3,
    OP_AND  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLTS = 4'd8,
    OP_SLTU = 4'd9,
    OP_EQ   = 4'd10,
    OP_NE   = 4'd11,
    OP_LTS  = 4'd12,
    OP_GES  = 4'd13,
    OP_LTU  = 4'd14,
    OP_GEU  = 4'd15
  } fu_op_t;

  typedef struct packed {
    fu_op_t                operator;
    logic [XLEN-1:0]       operand_a;
    logic [XLEN-1:0]       operand_b;
    logic [XLEN-1:0]       imm;
    logic [TRANS_ID_W-1:0] trans_id;
  } fu_data_t;

endpackage

module alu_issue_ctrl #(
  parameter int unsigned TRANS_ID_BITS = alu_issue_ctrl_pkg::TRANS_ID_W
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               issue_valid_i,
  output logic                               issue_ready_o,
  input  alu_issue_ctrl_pkg::fu_data_t       fu_data_i,
  output alu_issue_ctrl_pkg::fu_data_t       alu_fu_data_o,
  input  logic [alu_issue_ctrl_pkg::XLEN-1:0] alu_result_i,
  input  logic                               alu_branch_res_i,
  output logic                               wb_valid_o,
  input  logic                               wb_ready_i,
  output logic [alu_issue_ctrl_pkg::XLEN-1:0] wb_result_o,
  output logic [TRANS_ID_BITS-1:0]           wb_trans_id_o,
  output logic                               wb_branch_res_o
);

  localparam int unsigned XLEN = alu_issue_ctrl_pkg::XLEN;

`ifdef ALU_ISSUE_SKID_EN
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
`else
  localparam int unsigned DEPTH = 1;
  localparam int unsigned CNT_W = 1;
`endif

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0]             cnt_q;
  logic [CNT_W-1:0]             cnt_next;
  alu_issue_ctrl_pkg::fu_data_t head;
  logic                         buf_nonempty;
  logic                         enq;
  logic                         deq;
  logic                         slot_free;

  logic                         wb_valid_q;
  logic [XLEN-1:0]              wb_result_q;
  logic [TRANS_ID_BITS-1:0]     wb_trans_id_q;
  logic                         wb_branch_res_q;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  // Ready depends only on the count register, so back-pressure from the
  // writeback side reaches issue one cycle late rather than combinationally.
  assign buf_nonempty  = (cnt_q != '0);
  assign issue_ready_o = (cnt_q != CNT_FULL);
  assign enq           = issue_valid_i & issue_ready_o & ~flush_i;
  assign slot_free     = ~wb_valid_q | wb_ready_i;
  assign deq           = buf_nonempty & slot_free & ~flush_i;

  // enq is only possible below full and deq only above empty, so the
  // count never wraps.
  assign cnt_next = cnt_q + CNT_W'(enq) - CNT_W'(deq);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Instruction storage
  // -------------------------------------------------------------------------
`ifdef ALU_ISSUE_SKID_EN
  alu_issue_ctrl_pkg::fu_data_t mem_q [2];
  logic                         wr_ptr_q;
  logic                         rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (enq) begin
        mem_q[wr_ptr_q] <= fu_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (deq) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign head = mem_q[rd_ptr_q];
`else
  // Single holding register: enq only happens while empty, so it can never
  // collide with a deq of the same entry.
  alu_issue_ctrl_pkg::fu_data_t hold_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_q <= '0;
    end else if (enq) begin
      hold_q <= fu_data_i;
    end
  end

  assign head = hold_q;
`endif

  // Stored entries are never forwarded in their enqueue cycle; an empty
  // buffer shows the ALU an all-zero instruction.
  assign alu_fu_data_o = buf_nonempty ? head : '0;

  // -------------------------------------------------------------------------
  // Writeback slot
  // -------------------------------------------------------------------------
  // Flush clears only the valid flag; the stale payload is invisible behind
  // wb_valid_o = 0. A deq while the slot is being consumed overwrites it in
  // place, which keeps one result per cycle flowing.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_valid_q      <= 1'b0;
      wb_result_q     <= '0;
      wb_trans_id_q   <= '0;
      wb_branch_res_q <= 1'b0;
    end else if (flush_i) begin
      wb_valid_q      <= 1'b0;
    end else if (deq) begin
      wb_valid_q      <= 1'b1;
      wb_result_q     <= alu_result_i;
      wb_trans_id_q   <= TRANS_ID_BITS'(head.trans_id);
      wb_branch_res_q <= alu_branch_res_i;
    end else if (wb_ready_i) begin
      wb_valid_q      <= 1'b0;
    end
  end

  assign wb_valid_o      = wb_valid_q;
  assign wb_result_o     = wb_result_q;
  assign wb_trans_id_o   = wb_trans_id_q;
  assign wb_branch_res_o = wb_branch_res_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

`ifdef ALU_ISSUE_SKID_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  fu_data_t    fu_data_i;
  fu_data_t    alu_fu_data_o;
  logic [63:0] alu_result_i;
  logic        alu_branch_res_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [63:0] wb_result_o;
  logic [2:0]  wb_trans_id_o;
  logic        wb_branch_res_o;

  always #5 clk_i = ~clk_i;

  alu_issue_ctrl dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .issue_valid_i    (issue_valid_i),
    .issue_ready_o    (issue_ready_o),
    .fu_data_i        (fu_data_i),
    .alu_fu_data_o    (alu_fu_data_o),
    .alu_result_i     (alu_result_i),
    .alu_branch_res_i (alu_branch_res_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wb_result_o      (wb_result_o),
    .wb_trans_id_o    (wb_trans_id_o),
    .wb_branch_res_o  (wb_branch_res_o)
  );

  // ---------------- ALU stub ----------------
  typedef struct packed {
    logic        br;
    logic [63:0] res;
  } alu_out_t;

  function automatic alu_out_t alu_eval(fu_data_t d);
    alu_out_t    o;
    logic [63:0] a;
    logic [63:0] b;
    a = d.operand_a;
    b = d.operand_b;
    o.br  = 1'b0;
    o.res = '0;
    case (d.operator)
      OP_ADD:  o.res = a + b;
      OP_SUB:  o.res = a - b;
      OP_XOR:  o.res = a ^ b;
      OP_OR:   o.res = a | b;
      OP_AND:  o.res = a & b;
      OP_SLL:  o.res = a << b[5:0];
      OP_SRL:  o.res = a >> b[5:0];
      OP_SRA:  o.res = $signed(a) >>> b[5:0];
      OP_SLTS: o.res = {63'b0, $signed(a) < $signed(b)};
      OP_SLTU: o.res = {63'b0, a < b};
      OP_EQ:   o.br  = (a == b);
      OP_NE:   o.br  = (a != b);
      OP_LTS:  o.br  = ($signed(a) < $signed(b));
      OP_GES:  o.br  = ($signed(a) >= $signed(b));
      OP_LTU:  o.br  = (a < b);
      OP_GEU:  o.br  = (a >= b);
      default: o.res = '0;
    endcase
    return o;
  endfunction

  alu_out_t alu_o;
  assign alu_o            = alu_eval(alu_fu_data_o);
  assign alu_result_i     = alu_o.res;
  assign alu_branch_res_i = alu_o.br;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_head(string name, fu_data_t act, fu_data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  fu_data_t    mq[$];
  logic        m_valid;
  logic [63:0] m_res;
  logic [2:0]  m_tid;
  logic        m_br;

  task automatic model_update();
    alu_out_t o;
    fu_data_t h;
    logic     rdy;
    if (!rst_ni) begin
      mq.delete();
      m_valid = 1'b0;
      m_res   = '0;
      m_tid   = '0;
      m_br    = 1'b0;
    end else if (flush_i) begin
      mq.delete();
      m_valid = 1'b0;
    end else begin
      rdy = (mq.size() != D);
      if (mq.size() > 0 && (!m_valid || wb_ready_i)) begin
        h       = mq.pop_front();
        o       = alu_eval(h);
        m_valid = 1'b1;
        m_res   = o.res;
        m_tid   = h.trans_id;
        m_br    = o.br;
      end else if (wb_ready_i) begin
        m_valid = 1'b0;
      end
      if (issue_valid_i && rdy) mq.push_back(fu_data_i);
    end
  endtask

  task automatic check_model(string tag);
    fu_data_t eh;
    eh = '0;
    if (mq.size() > 0) eh = mq[0];
    chk({tag, ":issue_ready"}, issue_ready_o, mq.size() != D);
    chk({tag, ":wb_valid"}, wb_valid_o, m_valid);
    chk({tag, ":wb_result"}, wb_result_o, m_res);
    chk({tag, ":wb_trans_id"}, wb_trans_id_o, m_tid);
    chk({tag, ":wb_branch"}, wb_branch_res_o, m_br);
    chk_head({tag, ":alu_head"}, alu_fu_data_o, eh);
  endtask

  task automatic step();
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(logic iv, fu_data_t d, logic wbr, logic fl);
    issue_valid_i = iv;
    fu_data_i     = d;
    wb_ready_i    = wbr;
    flush_i       = fl;
  endtask

  function automatic fu_data_t mkop(fu_op_t op, logic [63:0] a, logic [63:0] b, logic [2:0] tid);
    fu_data_t d;
    d.operator  = op;
    d.operand_a = a;
    d.operand_b = b;
    d.imm       = '0;
    d.trans_id  = tid;
    return d;
  endfunction

  function automatic fu_data_t rand_op();
    fu_data_t d;
    d.operator  = fu_op_t'($urandom_range(0, 15));
    d.operand_a = {$urandom, $urandom};
    d.operand_b = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) d.operand_b = d.operand_a;
    d.imm       = {$urandom, $urandom};
    d.trans_id  = 3'($urandom);
    return d;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        iv;
    fu_op_t      op;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  tid;
    logic        wbr;
    logic        ev;
    logic [63:0] eres;
    logic [2:0]  etid;
    logic        ebr;
  } vec_t;

  vec_t vecs[12];

  int wb_tid[$];
  int wb_cyc[$];
  int k;
  int acc;

  initial begin
    vecs[0]  = '{1'b1, OP_ADD, 64'd5,  64'd7, 3'd3, 1'b0, 1'b0, 64'd0,  3'd0, 1'b0};
    vecs[1]  = '{1'b0, OP_ADD, 64'd0,  64'd0, 3'd0, 1'b0, 1'b1, 64'd12, 3'd3, 1'b0};
    vecs[2]  = '{1'b0, OP_ADD, 64'd0,  64'd0, 3'd0, 1'b0, 1'b1, 64'd12, 3'd3, 1'b0};
    vecs[3]  = '{1'b0, OP_ADD, 64'd0,  64'd0, 3'd0, 1'b0, 1'b1, 64'd12, 3'd3, 1'b0};
    vecs[4]  = '{1'b0, OP_ADD, 64'd0,  64'd0, 3'd0, 1'b1, 1'b0, 64'd0,  3'd0, 1'b0};
    vecs[5]  = '{1'b1, OP_EQ,  64'd9,  64'd9, 3'd1, 1'b1, 1'b0, 64'd0,  3'd0, 1'b0};
    vecs[6]  = '{1'b0, OP_ADD, 64'd0,  64'd0, 3'd0, 1'b1, 1'b1, 64'd0,  3'd1, 1'b1};
    vecs[7]  = '{1'b1, OP_NE,  64'd9,  64'd9, 3'd2, 1'b1, 1'b0, 64'd0,  3'd0, 1'b0};
    vecs[8]  = '{1'b0, OP_ADD, 64'd0,  64'd0, 3'd0, 1'b1, 1'b1, 64'd0,  3'd2, 1'b0};
    vecs[9]  = '{1'b1, OP_SUB, 64'd20, 64'd7, 3'd6, 1'b1, 1'b0, 64'd0,  3'd0, 1'b0};
    vecs[10] = '{1'b0, OP_ADD, 64'd0,  64'd0, 3'd0, 1'b0, 1'b1, 64'd13, 3'd6, 1'b0};
    vecs[11] = '{1'b0, OP_ADD, 64'd0,  64'd0, 3'd0, 1'b1, 1'b0, 64'd0,  3'd0, 1'b0};

    // ---- reset ----
    rst_ni = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_issue_ready", issue_ready_o, 1'b1);
    chk("rst_wb_valid", wb_valid_o, 1'b0);
    chk("rst_wb_result", wb_result_o, 64'd0);
    chk("rst_wb_trans_id", wb_trans_id_o, 3'd0);
    chk("rst_wb_branch", wb_branch_res_o, 1'b0);
    chk_head("rst_alu_head", alu_fu_data_o, '0);
    rst_ni = 1'b1;
    step();
    check_model("idle");

    // ---- table ----
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].iv, mkop(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tid), vecs[i].wbr, 1'b0);
      step();
      check_model("vec");
      chk($sformatf("vec%0d_wb_valid", i), wb_valid_o, vecs[i].ev);
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_wb_result", i), wb_result_o, vecs[i].eres);
        chk($sformatf("vec%0d_wb_trans_id", i), wb_trans_id_o, vecs[i].etid);
        chk($sformatf("vec%0d_wb_branch", i), wb_branch_res_o, vecs[i].ebr);
      end
    end

    // ---- streaming: 8 ops, consumer always ready ----
    wb_tid.delete();
    wb_cyc.delete();
    k = 0;
    for (int c = 0; c < 40; c++) begin
      if (wb_valid_o) begin
        wb_tid.push_back(int'(wb_trans_id_o));
        wb_cyc.push_back(c);
      end
      drive(k < 8, mkop(OP_ADD, 64'(k), 64'd1, k[2:0]), 1'b1, 1'b0);
      if (k < 8 && issue_ready_o) k++;
      step();
      check_model("stream");
    end
    chk("stream_wb_count", wb_tid.size(), 8);
    for (int i = 0; i < wb_tid.size() && i < 8; i++) begin
      chk($sformatf("stream_tid%0d", i), wb_tid[i], i);
      if (i > 0) chk($sformatf("stream_gap%0d", i), wb_cyc[i] - wb_cyc[i-1], 3 - D);
    end

    // ---- back-pressure: consumer stalled while 4 ops are offered ----
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      drive(acc < 4, mkop(OP_SUB, 64'd100, 64'(acc), acc[2:0]), 1'b0, 1'b0);
      if (acc < 4 && issue_ready_o) acc++;
      step();
      check_model("bp_fill");
    end
    chk("bp_accepted", acc, D + 1);
    chk("bp_ready_low", issue_ready_o, 1'b0);
    chk("bp_slot_valid", wb_valid_o, 1'b1);
    chk("bp_slot_tid", wb_trans_id_o, 3'd0);
    wb_tid.delete();
    for (int c = 0; c < 10; c++) begin
      if (wb_valid_o) wb_tid.push_back(int'(wb_trans_id_o));
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
      check_model("bp_drain");
    end
    chk("bp_drain_count", wb_tid.size(), D + 1);
    for (int i = 0; i < wb_tid.size(); i++)
      chk($sformatf("bp_drain_tid%0d", i), wb_tid[i], i);

    // ---- flush with full buffer and valid slot ----
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, mkop(OP_ADD, 64'(c), 64'(c), 3'(c)), 1'b0, 1'b0);
      step();
      check_model("fl_fill");
    end
    chk("fl_full_ready", issue_ready_o, 1'b0);
    chk("fl_full_valid", wb_valid_o, 1'b1);
    drive(1'b1, mkop(OP_ADD, 64'd1, 64'd1, 3'd7), 1'b1, 1'b1);
    step();
    check_model("fl");
    chk("fl_wb_valid", wb_valid_o, 1'b0);
    chk("fl_issue_ready", issue_ready_o, 1'b1);
    chk_head("fl_alu_head", alu_fu_data_o, '0);
    drive(1'b1, mkop(OP_ADD, 64'd40, 64'd2, 3'd5), 1'b1, 1'b0);
    step();
    check_model("fl_next");
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check_model("fl_next");
    chk("fl_next_valid", wb_valid_o, 1'b1);
    chk("fl_next_tid", wb_trans_id_o, 3'd5);
    chk("fl_next_result", wb_result_o, 64'd42);

    // ---- randomized traffic with occasional flush and reset ----
    for (int c = 0; c < 400; c++) begin
      rst_ni = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 9) < 6, rand_op(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 29) == 0);
      step();
      check_model("rand");
    end
    rst_ni = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
